mem_portb_arbiter: RTL and testbench

MEM_PORTB_ARBITER -- requirements
Module: mem_portb_arbiter

---
 rtl/mem_portb_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_portb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_portb_arbiter.sv
// Two-requester arbiter for memory port B: requester 0 (VGA fetch) has fixed priority,
// requester 1 writes are blocked in the protected low region, and reads return two cycles after ack.
module mem_portb_arbiter #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] PROTECT_TOP = 12'h0FF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err1,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic [DATA_WIDTH-1:0] mem_data_b,
    output logic                  mem_we_b,
    input  logic [DATA_WIDTH-1:0] mem_out_b
);

    // Handshake: a requester raises reqN with stable addr/we/wdata and holds it until it
    // sees the one-cycle ackN; a request is never considered while its own ack is high.
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  err1_q, err1_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rv0_q, rv0_d;
    logic                  rv1_q, rv1_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  tag1_vld_q, tag1_vld_d;
    logic                  tag1_id_q, tag1_id_d;
    logic                  tag2_vld_q, tag2_vld_d;
    logic                  tag2_id_q, tag2_id_d;

    logic issue0;
    logic issue1;
    logic prot_hit;

    always_comb begin
        issue0   = req0 && !ack0_q;
        issue1   = req1 && !ack1_q && !issue0;
        prot_hit = we1 && (addr1 <= PROTECT_TOP);

        ack0_d     = issue0;
        ack1_d     = issue1;
        err1_d     = issue1 && prot_hit;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        tag1_vld_d = 1'b0;
        tag1_id_d  = 1'b0;

        if (issue0) begin
            addr_d     = addr0;
            data_d     = wdata0;
            we_d       = we0;
            tag1_vld_d = !we0;
            tag1_id_d  = 1'b0;
        end else if (issue1) begin
            addr_d     = addr1;
            data_d     = wdata1;
            we_d       = we1 && !prot_hit;
            tag1_vld_d = !we1;
            tag1_id_d  = 1'b1;
        end

        // Stage 2 lines up with the cycle in which mem_out_b holds the read word.
        tag2_vld_d = tag1_vld_q;
        tag2_id_d  = tag1_id_q;
        rv0_d      = tag2_vld_q && !tag2_id_q;
        rv1_d      = tag2_vld_q && tag2_id_q;
        rdata_d    = tag2_vld_q ? mem_out_b : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err1_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            rdata_q    <= '0;
            tag1_vld_q <= 1'b0;
            tag1_id_q  <= 1'b0;
            tag2_vld_q <= 1'b0;
            tag2_id_q  <= 1'b0;
        end else begin
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err1_q     <= err1_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
            rdata_q    <= rdata_d;
            tag1_vld_q <= tag1_vld_d;
            tag1_id_q  <= tag1_id_d;
            tag2_vld_q <= tag2_vld_d;
            tag2_id_q  <= tag2_id_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign err1       = err1_q;
    assign mem_we_b   = we_q;
    assign mem_addr_b = addr_q;
    assign mem_data_b = data_q;
    assign rvalid0    = rv0_q;
    assign rvalid1    = rv1_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Bench for mem_portb_arbiter: directed vector table for the documented scenarios plus
// constrained-random traffic checked every cycle against a queue-based reference model.
module tb_mem_portb_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int OW = 6 + AW + DW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, rvalid0, rvalid1, err1, mem_we_b;
    logic [DW-1:0] rdata, mem_data_b, mem_out_b;
    logic [AW-1:0] mem_addr_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mem_portb_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err1(err1),
        .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_we_b(mem_we_b),
        .mem_out_b(mem_out_b)
    );

    // ---------------- port-B memory (registered read) ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        mem_out_b <= mem[mem_addr_b];
        if (mem_we_b) mem[mem_addr_b] <= mem_data_b;
    end

    // ---------------- reference model ----------------
    // Shadow memory takes writes at issue time; each read enqueues its expected word,
    // requester id and the cycle number on which rvalid must appear.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    bit            id_q [$];
    int            due_q [$];
    int            cyc = 0;
    logic          m_ack0 = 0, m_ack1 = 0, m_err = 0, m_we = 0, m_rv0 = 0, m_rv1 = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_rdata = '0;

    always @(posedge clk) begin
        bit g0, g1, pid;
        if (reset) begin
            m_ack0 = 0; m_ack1 = 0; m_err = 0; m_we = 0; m_rv0 = 0; m_rv1 = 0;
            m_addr = '0; m_data = '0; m_rdata = '0;
            exp_q.delete(); id_q.delete(); due_q.delete();
        end else begin
            cyc++;
            m_rv0 = 0; m_rv1 = 0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                pid = id_q.pop_front();
                m_rdata = exp_q.pop_front();
                if (pid) m_rv1 = 1; else m_rv0 = 1;
            end
            g0 = req0 && !m_ack0;
            g1 = req1 && !m_ack1 && !g0;
            m_ack0 = g0; m_ack1 = g1; m_err = 0; m_we = 0;
            if (g0) begin
                m_addr = addr0; m_data = wdata0;
                if (we0) begin
                    m_we = 1; shadow[addr0] = wdata0;
                end else begin
                    exp_q.push_back(shadow[addr0]); id_q.push_back(1'b0); due_q.push_back(cyc + 2);
                end
            end else if (g1) begin
                m_addr = addr1; m_data = wdata1;
                if (we1 && addr1 <= 12'h0FF) begin
                    m_err = 1;
                end else if (we1) begin
                    m_we = 1; shadow[addr1] = wdata1;
                end else begin
                    exp_q.push_back(shadow[addr1]); id_q.push_back(1'b1); due_q.push_back(cyc + 2);
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    function automatic logic [OW-1:0] pack(logic a0, logic a1, logic e, logic w, logic r0, logic r1,
                                           logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] rd);
        return {a0, a1, e, w, r0, r1, a, d, rd};
    endfunction

    task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] dut_out();
        return pack(ack0, ack1, err1, mem_we_b, rvalid0, rvalid1, mem_addr_b, mem_data_b, rdata);
    endfunction

    always @(negedge clk) begin
        if (chk_en)
            check("model", dut_out(), pack(m_ack0, m_ack1, m_err, m_we, m_rv0, m_rv1, m_addr, m_data, m_rdata));
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst, r0, r1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic add(logic rst, logic r0, logic r1, logic w0, logic w1,
                       logic [AW-1:0] a0, logic [AW-1:0] a1, logic [DW-1:0] d0, logic [DW-1:0] d1,
                       logic ea0, logic ea1, logic ee, logic ew, logic er0, logic er1,
                       logic [AW-1:0] ea, logic [DW-1:0] ed, logic [DW-1:0] erd);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.exp = pack(ea0, ea1, ee, ew, er0, er1, ea, ed, erd);
        vecs.push_back(v);
    endtask

    task automatic drive(logic rst, logic r0, logic r1, logic w0, logic w1,
                         logic [AW-1:0] a0, logic [AW-1:0] a1, logic [DW-1:0] d0, logic [DW-1:0] d1);
        reset = rst; req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    task automatic rand_req(output logic r, output logic w, output logic [AW-1:0] a, output logic [DW-1:0] d);
        r = ($urandom_range(0, 2) != 0);
        w = $urandom_range(0, 1);
        a = ($urandom_range(0, 3) == 0) ? AW'(12'h0FD + $urandom_range(0, 5)) : AW'($urandom_range(0, (1<<AW)-1));
        d = DW'($urandom);
    endtask

    initial begin
        logic          nr, nw;
        logic [AW-1:0] na;
        logic [DW-1:0] nd;

        for (int i = 0; i < (1<<AW); i++) begin
            mem[i] = '0; shadow[i] = '0;
        end
        mem[12'h010] = 16'hBEEF; shadow[12'h010] = 16'hBEEF;
        mem[12'h020] = 16'h2020; shadow[12'h020] = 16'h2020;
        mem[12'h021] = 16'h2121; shadow[12'h021] = 16'h2121;
        mem[12'h030] = 16'h3030; shadow[12'h030] = 16'h3030;
        mem[12'h031] = 16'h3131; shadow[12'h031] = 16'h3131;
        mem[12'h0FF] = 16'h00FF; shadow[12'h0FF] = 16'h00FF;

        //   rst r0 r1 w0 w1  a0      a1      d0 d1        ack0 ack1 err we rv0 rv1 addr    data      rdata
        add(1, 1, 0, 0, 0, 12'h010, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 16'h0000);
        add(0, 1, 0, 0, 0, 12'h010, 12'h000, 0, 0,          1, 0, 0, 0, 0, 0, 12'h010, 16'h0000, 16'h0000);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h010, 16'h0000, 16'h0000);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 1, 0, 12'h010, 16'h0000, 16'hBEEF);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h010, 16'h0000, 16'hBEEF);
        add(0, 1, 1, 0, 0, 12'h030, 12'h031, 0, 0,          1, 0, 0, 0, 0, 0, 12'h030, 16'h0000, 16'hBEEF);
        add(0, 1, 1, 0, 0, 12'h030, 12'h031, 0, 0,          0, 1, 0, 0, 0, 0, 12'h031, 16'h0000, 16'hBEEF);
        add(0, 1, 1, 0, 0, 12'h030, 12'h031, 0, 0,          1, 0, 0, 0, 1, 0, 12'h030, 16'h0000, 16'h3030);
        add(0, 1, 1, 0, 0, 12'h030, 12'h031, 0, 0,          0, 1, 0, 0, 0, 1, 12'h031, 16'h0000, 16'h3131);
        add(0, 1, 1, 0, 0, 12'h030, 12'h031, 0, 0,          1, 0, 0, 0, 1, 0, 12'h030, 16'h0000, 16'h3030);
        add(0, 1, 1, 0, 0, 12'h030, 12'h031, 0, 0,          0, 1, 0, 0, 0, 1, 12'h031, 16'h0000, 16'h3131);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 1, 0, 12'h031, 16'h0000, 16'h3030);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 1, 12'h031, 16'h0000, 16'h3131);
        add(0, 0, 1, 0, 1, 12'h000, 12'h0FF, 0, 16'hDEAD,   0, 1, 1, 0, 0, 0, 12'h0FF, 16'hDEAD, 16'h3131);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h0FF, 16'hDEAD, 16'h3131);
        add(0, 0, 1, 0, 1, 12'h000, 12'h100, 0, 16'h1234,   0, 1, 0, 1, 0, 0, 12'h100, 16'h1234, 16'h3131);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h100, 16'h1234, 16'h3131);
        add(0, 0, 1, 0, 0, 12'h000, 12'h100, 0, 0,          0, 1, 0, 0, 0, 0, 12'h100, 16'h0000, 16'h3131);
        add(0, 1, 0, 0, 0, 12'h0FF, 12'h000, 0, 0,          1, 0, 0, 0, 0, 0, 12'h0FF, 16'h0000, 16'h3131);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 1, 12'h0FF, 16'h0000, 16'h1234);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 1, 0, 12'h0FF, 16'h0000, 16'h00FF);
        add(0, 1, 0, 0, 0, 12'h020, 12'h000, 0, 0,          1, 0, 0, 0, 0, 0, 12'h020, 16'h0000, 16'h00FF);
        add(0, 0, 1, 0, 0, 12'h000, 12'h021, 0, 0,          0, 1, 0, 0, 0, 0, 12'h021, 16'h0000, 16'h00FF);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 1, 0, 12'h021, 16'h0000, 16'h2020);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 1, 12'h021, 16'h0000, 16'h2121);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h021, 16'h0000, 16'h2121);
        add(0, 1, 0, 0, 0, 12'h010, 12'h000, 0, 0,          1, 0, 0, 0, 0, 0, 12'h010, 16'h0000, 16'h2121);
        add(1, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 16'h0000);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 16'h0000);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 16'h0000);
        add(0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 0,          0, 0, 0, 0, 0, 0, 12'h000, 16'h0000, 16'h0000);

        // ---------------- reset ----------------
        drive(1, 0, 0, 0, 0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("reset_state", dut_out(), '0);
        chk_en = 1'b1;

        // ---------------- directed table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // ---------------- random traffic ----------------
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 249) == 0);
            if (!req0 || ack0) begin
                rand_req(nr, nw, na, nd);
                req0 = nr; we0 = nw; addr0 = na; wdata0 = nd;
            end
            if (!req1 || ack1) begin
                rand_req(nr, nw, na, nd);
                req1 = nr; we1 = nw; addr1 = na; wdata1 = nd;
            end
            @(negedge clk);
        end

        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
